// File: rtl/pong_pkg.sv
// Shared Pong definitions: sequencer states, pixel colour type and screen geometry
// defaults used by the background, paddle and ball generators.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLASH = 2'd2
  } state_t;

  typedef logic [2:0] rgb_t;

  localparam rgb_t COLOR_BLACK  = 3'b000;
  localparam rgb_t COLOR_BORDER = 3'b101;
  localparam rgb_t COLOR_NET    = 3'b111;
  localparam rgb_t COLOR_FLASH  = 3'b100;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int WALL_LINE     = 5;
  localparam int NET_W         = 4;
  localparam int NET_DASH_LOG2 = 4;

endpackage

// File: rtl/flash_sequencer.sv
// Goal-flash sequencer: remembers the conceding side, waits for a frame boundary,
// then counts flash frames and reports the blink phase to the pixel path.
//   state | meaning
//   IDLE  | no flash pending, walls drawn normally
//   ARMED | goal seen, waiting for the next frame_start to begin flashing
//   FLASH | flashing the latched side's wall, fcnt counts frames
module flash_sequencer
  import pong_pkg::*;
#(
  parameter int FLASH_FRAMES = 6,
  parameter int BLINK_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic goal,
  input  logic goal_side,
  output logic busy,
  output logic flashing,
  output logic flash_on,
  output logic side
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(FLASH_FRAMES - 1);
  localparam logic [31:0] BLINK_U = 32'(BLINK_FRAMES);

  state_t          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            side_q, side_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      side_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      side_q  <= side_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    side_d  = side_q;
    case (state_q)
      IDLE: begin
        if (goal) begin
          side_d  = goal_side;
          state_d = ARMED;
        end
      end
      ARMED: begin
        // a goal coinciding with frame_start still decides which side flashes
        if (goal) side_d = goal_side;
        if (frame_start) begin
          state_d = FLASH;
          fcnt_d  = '0;
        end
      end
      FLASH: begin
        if (goal) begin
          side_d  = goal_side;
          state_d = ARMED;
          fcnt_d  = '0;
        end else if (frame_start) begin
          if (fcnt_q == LAST_FRAME) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign flashing = (state_q == FLASH);
  assign flash_on = ((32'(fcnt_q) / BLINK_U) & 32'd1) == 32'd0;
  assign side     = side_q;

endmodule

// File: rtl/background_field.sv
// Playfield background: wall frame, dashed centre net and goal-side wall flash,
// registered so rgb lags row/col by exactly one clock.
module background_field
  import pong_pkg::*;
#(
  parameter int   WIDTH        = SCREEN_WIDTH,
  parameter int   HEIGHT       = SCREEN_HEIGHT,
  parameter int   LINE         = WALL_LINE,
  parameter int   NET_WIDTH    = NET_W,
  parameter int   DASH_LOG2    = NET_DASH_LOG2,
  parameter rgb_t BORDER_COLOR = COLOR_BORDER,
  parameter rgb_t NET_COLOR    = COLOR_NET,
  parameter rgb_t FLASH_COLOR  = COLOR_FLASH,
  parameter int   FLASH_FRAMES = 6,
  parameter int   BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       frame_start,
  input  logic       goal,
  input  logic       goal_side,
  output logic [2:0] rgb,
  output logic       busy
);

  // 12-bit geometry keeps WIDTH-LINE and the net bounds from wrapping
  localparam logic [11:0] W_X     = 12'(WIDTH);
  localparam logic [11:0] H_Y     = 12'(HEIGHT);
  localparam logic [11:0] LINE_XY = 12'(LINE);
  localparam logic [11:0] RIGHT_X = 12'(WIDTH - LINE);
  localparam logic [11:0] BOT_Y   = 12'(HEIGHT - LINE);
  localparam logic [11:0] NET_LO  = 12'(WIDTH / 2 - NET_WIDTH / 2);
  localparam logic [11:0] NET_HI  = 12'(WIDTH / 2 - NET_WIDTH / 2 + NET_WIDTH);

  logic flashing, flash_on, side;
  rgb_t rgb_q, rgb_d;

  flash_sequencer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .goal        (goal),
    .goal_side   (goal_side),
    .busy        (busy),
    .flashing    (flashing),
    .flash_on    (flash_on),
    .side        (side)
  );

  logic [11:0] row_x, col_x;
  logic        visible, left_wall, right_wall, tb_wall, net;
  rgb_t        flash_rgb;

  always_comb begin
    row_x      = {2'b00, row};
    col_x      = {2'b00, col};
    visible    = (row_x < H_Y) && (col_x < W_X);
    left_wall  = (col_x < LINE_XY);
    right_wall = (col_x >= RIGHT_X);
    tb_wall    = (row_x < LINE_XY) || (row_x >= BOT_Y);
    net        = (col_x >= NET_LO) && (col_x < NET_HI) && (row[DASH_LOG2] == 1'b0);
    flash_rgb  = flash_on ? FLASH_COLOR : COLOR_BLACK;

    rgb_d = COLOR_BLACK;
    if (!visible) begin
      rgb_d = COLOR_BLACK;
    end else if (left_wall) begin
      rgb_d = (flashing && !side) ? flash_rgb : BORDER_COLOR;
    end else if (right_wall) begin
      rgb_d = (flashing && side) ? flash_rgb : BORDER_COLOR;
    end else if (tb_wall) begin
      rgb_d = BORDER_COLOR;
    end else if (net) begin
      rgb_d = NET_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= COLOR_BLACK;
    else        rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_background_field.sv
// Self-checking bench for background_field: directed test-plan scenarios plus
// randomized pixels/frame/goal traffic against a behavioural reference model.
module tb_background_field;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] row = '0, col = '0;
  logic       frame_start = 1'b0, goal = 1'b0, goal_side = 1'b0;
  logic [2:0] rgb;
  logic       busy;

  logic [9:0] row_s = '0, col_s = '0;
  logic [2:0] rgb_s;
  logic       busy_s;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mode 0 idle, 1 waiting for frame, 2 flashing
  int m_mode  = 0;
  int m_frame = 0;
  bit m_side  = 1'b0;

  always #5 clk = ~clk;

  background_field u_dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .frame_start(frame_start), .goal(goal), .goal_side(goal_side),
    .rgb(rgb), .busy(busy)
  );

  background_field #(.WIDTH(320), .LINE(8), .NET_WIDTH(2), .DASH_LOG2(3)) u_small (
    .clk(clk), .rst_n(rst_n), .row(row_s), .col(col_s),
    .frame_start(1'b0), .goal(1'b0), .goal_side(1'b0),
    .rgb(rgb_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_pixel(input int r, input int c, input int w, input int h,
                                           input int line, input int nw, input int dl,
                                           input bit flashing, input bit on, input bit side);
    logic [2:0] fl;
    fl = on ? 3'b100 : 3'b000;
    if (r >= h || c >= w) return 3'b000;
    if (c < line) return (flashing && !side) ? fl : 3'b101;
    if (c >= w - line) return (flashing && side) ? fl : 3'b101;
    if (r < line || r >= h - line) return 3'b101;
    if (c >= w/2 - nw/2 && c < w/2 - nw/2 + nw && ((r >> dl) & 1) == 0) return 3'b111;
    return 3'b000;
  endfunction

  function automatic void model_step(input bit fs, input bit g, input bit gs);
    if (m_mode == 0) begin
      if (g) begin m_side = gs; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (g) m_side = gs;
      if (fs) begin m_mode = 2; m_frame = 0; end
    end else begin
      if (g) begin
        m_side = gs; m_mode = 1; m_frame = 0;
      end else if (fs) begin
        if (m_frame == 5) begin m_mode = 0; m_frame = 0; end
        else m_frame++;
      end
    end
  endfunction

  task automatic cyc(input int r, input int c, input bit fs, input bit g, input bit gs);
    logic [2:0] exp;
    row = r[9:0]; col = c[9:0];
    frame_start = fs; goal = g; goal_side = gs;
    exp = ref_pixel(r, c, 640, 480, 5, 4, 4, m_mode == 2, ((m_frame / 2) % 2) == 0, m_side);
    @(posedge clk); #1;
    chk("rgb", {29'd0, rgb}, {29'd0, exp});
    model_step(fs, g, gs);
    chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
  endtask

  task automatic px(input int r, input int c, input logic [2:0] lit);
    cyc(r, c, 1'b0, 1'b0, 1'b0);
    chk("plan_rgb", {29'd0, rgb}, {29'd0, lit});
  endtask

  task automatic small_px(input int r, input int c, input logic [2:0] lit);
    row_s = r[9:0]; col_s = c[9:0];
    @(posedge clk); #1;
    chk("small_model", {29'd0, rgb_s}, {29'd0, ref_pixel(r, c, 320, 480, 8, 2, 3, 1'b0, 1'b0, 1'b0)});
    chk("small_plan", {29'd0, rgb_s}, {29'd0, lit});
  endtask

  task automatic scenario1();
    px(2, 100, 3'b101);
    px(479, 300, 3'b101);
    px(100, 638, 3'b101);
    px(5, 318, 3'b111);
    px(20, 320, 3'b000);
    px(200, 200, 3'b000);
    px(490, 10, 3'b000);
  endtask

  initial begin
    int rsel[11];
    int csel[11];
    rsel = '{0, 4, 5, 15, 16, 31, 32, 474, 475, 479, 480};
    csel = '{0, 4, 5, 317, 318, 321, 322, 634, 635, 639, 640};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", {29'd0, rgb}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    scenario1();

    // goal on the left, then the full six-frame blink
    cyc(100, 2, 1'b0, 1'b1, 1'b0);
    px(100, 2, 3'b101);
    chk("armed_busy", {31'd0, busy}, 32'd1);
    for (int f = 0; f < 6; f++) begin
      cyc(100, 2, 1'b1, 1'b0, 1'b0);
      px(100, 2, ((f / 2) % 2 == 0) ? 3'b100 : 3'b000);
      px(100, 637, 3'b101);
    end
    cyc(100, 2, 1'b1, 1'b0, 1'b0);
    px(100, 2, 3'b101);
    chk("done_busy", {31'd0, busy}, 32'd0);

    // right-side goal interrupts the left flash in frame 3
    cyc(100, 2, 1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) cyc(100, 2, 1'b1, 1'b0, 1'b0);
    px(100, 2, 3'b000);
    cyc(100, 2, 1'b0, 1'b1, 1'b1);
    px(100, 2, 3'b101);
    px(100, 637, 3'b101);
    for (int f = 0; f < 6; f++) begin
      cyc(100, 637, 1'b1, 1'b0, 1'b0);
      px(100, 637, ((f / 2) % 2 == 0) ? 3'b100 : 3'b000);
      px(100, 2, 3'b101);
    end
    cyc(100, 637, 1'b1, 1'b0, 1'b0);
    px(100, 637, 3'b101);

    // goal and frame_start together while armed
    cyc(100, 2, 1'b0, 1'b1, 1'b0);
    cyc(100, 2, 1'b1, 1'b1, 1'b1);
    px(100, 637, 3'b100);
    px(100, 2, 3'b101);

    // asynchronous reset during an on-phase
    px(100, 637, 3'b100);
    #($urandom_range(1, 7));
    rst_n = 1'b0;
    #1;
    chk("async_rgb", {29'd0, rgb}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    m_mode = 0; m_frame = 0; m_side = 1'b0;
    frame_start = 1'b0; goal = 1'b0;
    @(posedge clk); #1;
    chk("held_rgb", {29'd0, rgb}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    scenario1();

    small_px(100, 312, 3'b101);
    small_px(9, 159, 3'b000);
    small_px(3, 160, 3'b101);
    small_px(8, 160, 3'b000);
    small_px(16, 160, 3'b111);

    for (int i = 0; i < 3000; i++) begin
      int r, c;
      r = ($urandom % 2 == 0) ? int'($urandom_range(0, 519)) : rsel[$urandom_range(0, 10)];
      c = ($urandom % 2 == 0) ? int'($urandom_range(0, 700)) : csel[$urandom_range(0, 10)];
      cyc(r, c, ($urandom % 25) == 0, ($urandom % 90) == 0, $urandom % 2 == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
